// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - Single-issue sequencer feeding an external ALU from an 8x8 register file
module alu_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [14:0] instr,
    output logic        instr_ready,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [2:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [5:0]  alu_op,
    output logic        alu_start,
    input  logic [15:0] alu_result,
    input  logic        alu_done,
    output logic        wb_valid,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [1:0]  flags,
    output logic [1:0]  err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    // Wait counter only has to reach TIMEOUT-1; keep at least one bit.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [2:0]    state;
    logic [14:0]   instr_q;
    logic [CW-1:0] wait_cnt;
    logic [7:0]    regs [0:7];

    logic [5:0] op_q;
    logic [2:0] rd_q;
    logic [2:0] rs1_q;
    logic [2:0] rs2_q;

    assign op_q  = instr_q[14:9];
    assign rd_q  = instr_q[8:6];
    assign rs1_q = instr_q[5:3];
    assign rs2_q = instr_q[2:0];

    // Handshake and pulses decode straight from state so an async reset drops them immediately.
    always_comb begin
        instr_ready = (state == S_IDLE) && !reset;
        alu_start   = (state == S_ISSUE);
        wb_valid    = (state == S_WB);
        rd_data     = regs[rd_addr];
    end

    // Control FSM: fetch operands, issue to the ALU, wait with timeout, write back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            instr_q  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            wait_cnt <= '0;
            wb_addr  <= '0;
            wb_data  <= '0;
            flags    <= '0;
            err      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (op_q > 6'd8) begin
                        err[0] <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        // Nonblocking reads see the register file before any same-edge write.
                        alu_a  <= regs[rs1_q];
                        alu_b  <= regs[rs2_q];
                        alu_op <= op_q;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        wb_data <= alu_result;
                        wb_addr <= rd_q;
                        state   <= S_WB;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        err[1] <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_WB: begin
                    flags <= {(|wb_data[15:8]), ~(|wb_data)};
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register file: external preload in any state; writeback is ordered last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            if (state == S_WB) begin
                regs[wb_addr] <= wb_data[7:0];
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - Scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [14:0] instr = '0;
    logic        instr_ready;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [5:0]  alu_op;
    logic        alu_start;
    logic [15:0] alu_result = '0;
    logic        alu_done;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [1:0]  flags;
    logic [1:0]  err;

    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;
    logic        alu_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int start_count = 0;

    logic [18:0] sb [$];
    logic [18:0] sb_head;
    logic [7:0]  mirror [8];
    logic [1:0]  exp_flags = '0;

    alu_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_done(alu_done),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flags(flags), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'd0: return 16'(a) + 16'(b);
            6'd1: return 16'(a) - 16'(b);
            6'd2: return 16'(a) * 16'(b);
            6'd3: return {8'h00, a & b};
            6'd4: return {8'h00, a | b};
            6'd5: return {8'h00, a ^ b};
            6'd6: return 16'(a) << b[2:0];
            6'd7: return 16'(a >> b[2:0]);
            default: return 16'(a);
        endcase
    endfunction

    // ALU answers one cycle after it samples start
    assign alu_done = model_done | spur_done;
    always @(posedge clk) begin
        model_done <= alu_start & alu_en;
        alu_result <= alu_model(alu_op, alu_a, alu_b);
    end

    // Writeback monitor pops the scoreboard
    always @(negedge clk) begin
        if (alu_start) start_count++;
        if (wb_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected addr=%0d data=%h required=none", wb_addr, wb_data);
            end else begin
                sb_head = sb.pop_front();
                if ({wb_addr, wb_data} !== sb_head) begin
                    errors++;
                    $display("FAIL wb_data got addr=%0d data=%h required addr=%0d data=%h",
                             wb_addr, wb_data, sb_head[18:16], sb_head[15:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout got=%b required=1", instr_ready);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || instr_ready !== 1'b1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout pending=%0d ready=%b required pending=0 ready=1", sb.size(), instr_ready);
        end
    endtask

    task automatic preload(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
        mirror[addr] = data;
    endtask

    task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input bit expect_wb);
        logic [15:0] r;
        wait_ready();
        if (expect_wb) begin
            r = alu_model(op, mirror[rs1], mirror[rs2]);
            sb.push_back({rd, r});
            mirror[rd] = r[7:0];
            exp_flags = {(r[15:8] != 8'h00), (r == 16'h0000)};
        end
        instr = {op, rd, rs1, rs2};
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        @(negedge clk);
        checks++;
        if ({instr_ready, alu_start, wb_valid, err, flags, wb_addr, wb_data, alu_a, alu_b, alu_op} !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b start=%b wb=%b err=%b flags=%b required all zero",
                     instr_ready, alu_start, wb_valid, err, flags);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b required=1", instr_ready);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            if (rd_data !== 8'h00) bad++;
            mirror[i] = 8'h00;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_regs nonzero=%0d required=0", bad);
        end
    endtask

    task automatic test_add_latency();
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);
        issue(6'd0, 3'd3, 3'd1, 3'd2, 1'b1);
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b0 || alu_start !== 1'b0) begin
            errors++;
            $display("FAIL add_fetch ready=%b start=%b required 0 0", instr_ready, alu_start);
        end
        @(negedge clk);
        checks++;
        if (alu_start !== 1'b1) begin
            errors++;
            $display("FAIL add_start got=%b required=1", alu_start);
        end
        @(negedge clk);
        checks++;
        if (alu_start !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_wait start=%b wb=%b required 0 0", alu_start, wb_valid);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 16'h0008) begin
            errors++;
            $display("FAIL add_wb valid=%b data=%h required 1 0008", wb_valid, wb_data);
        end
        @(negedge clk);
        rd_addr = 3'd3;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || rd_data !== 8'h08 || flags !== 2'b00) begin
            errors++;
            $display("FAIL add_after ready=%b wb=%b r3=%h flags=%b required 1 0 08 00",
                     instr_ready, wb_valid, rd_data, flags);
        end
    endtask

    task automatic test_mul();
        preload(3'd1, 8'h20);
        preload(3'd2, 8'h10);
        issue(6'd2, 3'd4, 3'd1, 3'd2, 1'b1);
        wait_done();
        rd_addr = 3'd4;
        #1;
        checks++;
        if (rd_data !== mirror[4] || flags !== exp_flags || flags !== 2'b10) begin
            errors++;
            $display("FAIL mul r4=%h flags=%b required r4=%h flags=%b", rd_data, flags, mirror[4], exp_flags);
        end
    endtask

    task automatic test_illegal();
        int sc = start_count;
        issue(6'd9, 3'd5, 3'd1, 3'd2, 1'b0);
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL illegal_fetch ready=%b required=0", instr_ready);
        end
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1 || err !== 2'b01 || start_count != sc) begin
            errors++;
            $display("FAIL illegal ready=%b err=%b starts=%0d required 1 01 %0d",
                     instr_ready, err, start_count, sc);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        alu_en = 1'b0;
        issue(6'd0, 3'd6, 3'd1, 3'd2, 1'b0);
        while (alu_start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) begin
                checks++;
                if (err[1] !== 1'b0 || instr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early err=%b ready=%b required err1=0 ready=0", err, instr_ready);
                end
            end
        end
        checks++;
        if (err !== 2'b11 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout err=%b ready=%b required 11 1", err, instr_ready);
        end
        alu_en = 1'b1;
        issue(6'd1, 3'd6, 3'd1, 3'd2, 1'b1);
        wait_done();
        rd_addr = 3'd6;
        #1;
        checks++;
        if (rd_data !== mirror[6]) begin
            errors++;
            $display("FAIL after_timeout r6=%h required=%h", rd_data, mirror[6]);
        end
    endtask

    task automatic test_fetch_write();
        issue(6'd0, 3'd7, 3'd1, 3'd2, 1'b1);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h77;
        @(posedge clk);
        #1 wr_en = 1'b0;
        mirror[1] = 8'h77;
        wait_done();
        rd_addr = 3'd1;
        #1;
        checks++;
        if (rd_data !== 8'h77) begin
            errors++;
            $display("FAIL fetch_write r1=%h required=77", rd_data);
        end
    endtask

    task automatic test_same_edge();
        int n = 0;
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);
        issue(6'd0, 3'd3, 3'd1, 3'd2, 1'b1);
        while (wb_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hAA;
        @(posedge clk);
        #1 wr_en = 1'b0;
        rd_addr = 3'd3;
        #1;
        checks++;
        if (rd_data !== 8'h08) begin
            errors++;
            $display("FAIL same_edge r3=%h required=08", rd_data);
        end
    endtask

    task automatic test_spurious_done();
        int sc = start_count;
        @(negedge clk);
        spur_done = 1'b1;
        repeat (3) @(negedge clk);
        spur_done = 1'b0;
        checks++;
        if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || start_count != sc) begin
            errors++;
            $display("FAIL spurious_done ready=%b wb=%b required 1 0", instr_ready, wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            issue(6'($urandom_range(0, 8)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1);
        end
        wait_done();
        checks++;
        if (flags !== exp_flags || err !== 2'b11) begin
            errors++;
            $display("FAIL back_to_back flags=%b err=%b required %b 11", flags, err, exp_flags);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int bad = 0;
        issue(6'd0, 3'd2, 3'd1, 3'd2, 1'b1);
        while (alu_start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (alu_start !== 1'b0 || instr_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid start=%b ready=%b wb=%b required 0 0 0", alu_start, instr_ready, wb_valid);
        end
        sb.delete();
        for (int i = 0; i < 8; i++) mirror[i] = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || err !== 2'b00 || flags !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_after ready=%b err=%b flags=%b required 1 00 00", instr_ready, err, flags);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            if (rd_data !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_regs nonzero=%0d required=0", bad);
        end
        repeat (4) @(negedge clk);
        preload(3'd1, 8'h09);
        preload(3'd2, 8'h04);
        issue(6'd5, 3'd0, 3'd1, 3'd2, 1'b1);
        wait_done();
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_mul();
        test_illegal();
        test_timeout();
        test_fetch_write();
        test_same_edge();
        test_spurious_done();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before the operation is abandoned.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr_valid  input  1  instruction offered.
REQ-005 SHALL have port instr  input  15  [14:9]=op, [8:6]=rd, [5:3]=rs1, [2:0]=rs2.
REQ-006 SHALL have port instr_ready  output  1  instruction accepted when valid & ready at a clk edge.
REQ-007 SHALL have port wr_en  input  1  external register-file write strobe (preload).
REQ-008 SHALL have port wr_addr  input  3  external write address.
REQ-009 SHALL have port wr_data  input  8  external write data.
REQ-010 SHALL have port rd_addr  input  3  debug read address.
REQ-011 SHALL have port rd_data  output  8  combinational read of reg[rd_addr].
REQ-012 SHALL have port alu_a  output  8  ALU operand a (registered).
REQ-013 SHALL have port alu_b  output  8  ALU operand b (registered).
REQ-014 SHALL have port alu_op  output  6  ALU opcode (registered).
REQ-015 SHALL have port alu_start  output  1  one-cycle ALU start pulse.
REQ-016 SHALL have port alu_result  input  16  ALU result.
REQ-017 SHALL have port alu_done  input  1  ALU completion, high the cycle after start is sampled.
REQ-018 SHALL have port wb_valid  output  1  one-cycle writeback pulse.
REQ-019 SHALL have port wb_addr  output  3  destination register of the writeback.
REQ-020 SHALL have port wb_data  output  16  full ALU result written back.
REQ-021 SHALL have port flags  output  2  [0]=zero (result==0), [1]=hi (result[15:8]!=0); updated on writeback only.
REQ-022 SHALL have port err  output  2  sticky: [0]=illegal opcode, [1]=ALU timeout.

Function
REQ-023 SHALL hold an 8x8-bit register file reg[0..7].
REQ-024 SHALL implement states IDLE, FETCH, ISSUE, WAIT, WB.
REQ-025 SHALL drive instr_ready=1 only in IDLE and only when reset is low.
REQ-026 IDLE: accept at edge E0 latches instr and moves to FETCH; no accept stays IDLE.
REQ-027 FETCH: if op>8, set err[0], no ALU access, return to IDLE; otherwise, at edge E1, register alu_a=reg[rs1], alu_b=reg[rs2], alu_op=op and move to ISSUE.
REQ-028 ISSUE: alu_start=1 for exactly this one cycle; edge E2 moves to WAIT.
REQ-029 WAIT: alu_start=0; when alu_done=1 at an edge, capture alu_result and move to WB; a wait counter increments each WAIT cycle.
REQ-030 WAIT: if TIMEOUT cycles elapse without alu_done, set err[1] and return to IDLE with no writeback.
REQ-031 WB: wb_valid=1, wb_addr=rd, wb_data=captured result, reg[rd]=result[7:0], flags updated; next edge moves to IDLE.
REQ-032 Nominal latency SHALL be: accept at E0, alu_start high E1-E2, wb_valid high in cycle E3-E4, instr_ready high again from E4.
REQ-033 SHALL make rs1==rs2 and rd==rs1 legal; operands are read in FETCH, before the write.
REQ-034 External wr_en SHALL write in any state; if it hits the same address at the same edge as the WB write, the WB write SHALL win.
REQ-035 An external write in the FETCH-edge cycle SHALL NOT be visible to that fetch (old value used).
REQ-036 alu_done seen outside WAIT SHALL be ignored.
REQ-037 err bits SHALL clear only on reset.

Reset
REQ-038 Reset SHALL asynchronously force IDLE, all reg[]=0, alu_a/alu_b/alu_op=0, alu_start=0, wb_valid=0, wb_addr=0, wb_data=0, flags=0, err=0, wait counter=0.
REQ-039 Reset mid-operation SHALL abort with no writeback; alu_start SHALL drop in the same cycle.
REQ-040 instr_ready SHALL be 1 from the first cycle after reset deasserts.

Verification
REQ-041 Preload r1=5, r2=3; issue op=0 rd=3 -> alu_start one cycle; wb_data=0x0008; r3=8; flags=00; ready restored at E4.
REQ-042 Preload r1=0x20, r2=0x10; issue op=2 (mul) rd=4 -> wb_data equals the ALU result; r4=result[7:0]; flags[1]=1 iff result[15:8]!=0.
REQ-043 Issue op=9 -> no alu_start; err=01; no wb_valid; instr_ready restored after 2 cycles.
REQ-044 ALU model holds alu_done low -> err[1]=1 after 15 WAIT cycles; no writeback; the next instruction executes normally.
REQ-045 Same-edge ext write r3=0xAA and WB r3=0x08 -> r3=0x08; reset asserted in WAIT -> alu_start=0, no wb_valid, r[]=0.
